// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared constants, helpers and types for the multiplier arbiter.
//   DEF_WIDTH   - default operand width (must match the multiplier).
//   DEF_NREQ    - default number of requesters (2..8).
//   DEF_MUL_LAT - default multiplier latency, operands driven to product valid.
//   idw_of()    - requester id width for a given requester count.
//   tag_t       - one stage of the in-flight owner tag pipeline.
// The tag id width follows DEF_NREQ; a build with a different NREQ must change
// DEF_NREQ here so the tag type and the arbiter agree.
package mult_arb_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_MUL_LAT = 2;

    // Id width: clog2(n), with a floor of one bit so NREQ=2 still has an id.
    function automatic int idw_of(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    localparam int DEF_IDW = idw_of(DEF_NREQ);

    typedef struct packed {
        logic               vld;
        logic [DEF_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester-facing request/response bundle of mult_arbiter.
//   req_valid/req_ready - per-requester valid/ready handshake (ready one-hot or zero)
//   req_a/req_b         - packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_id    - one-hot 1-cycle result strobe and owner id
//   rsp_lo/rsp_hi       - low/high product words
// Modports: master = requester side, slave = arbiter side.
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = idw_of(NREQ)
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_lo;
    logic [WIDTH-1:0]      rsp_hi;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi
    );

endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over NREQ request lines.
//   clk, rst - clock and synchronous active-high reset
//   en       - grant enable; no grant while low
//   req      - request vector
//   adv      - the current grant was accepted; move the pointer to it
//   grant    - one-hot grant (or zero), combinational
//   grant_id - index of the winner (meaningful while grant is non-zero)
// Optional macro MULT_ARB_PRIO0_EN: requester 0 has strict priority and the
// pointer only tracks grants to requesters 1..NREQ-1.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0]  last_q;
    logic [IDW-1:0]  last_d;
    logic [NREQ-1:0] cand_s;
    logic [IDW:0]    idx_s;
    logic [IDW-1:0]  win_s;
    logic            found_s;

    // Winner search: first candidate at or after last+1, wrapping mod NREQ.
    always_comb begin
        cand_s  = req;
`ifdef MULT_ARB_PRIO0_EN
        cand_s[0] = 1'b0;
`endif
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = {1'b0, last_q} + (IDW+1)'(k);
            if (idx_s >= (IDW+1)'(NREQ)) begin
                idx_s = idx_s - (IDW+1)'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && cand_s[idx_s[IDW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
`ifdef MULT_ARB_PRIO0_EN
        // Requester 0 overrides the rotating search whenever it asks.
        if (req[0]) begin
            found_s = 1'b1;
            win_s   = '0;
        end else begin
            found_s = found_s;
        end
`endif
    end

    // Grant decode, gated by en.
    always_comb begin
        grant = '0;
        if (en && found_s) begin
            grant[win_s] = 1'b1;
        end else begin
            grant = '0;
        end
        grant_id = win_s;
    end

    // Pointer next state: moves only on an accepted grant.
    always_comb begin
        last_d = last_q;
`ifdef MULT_ARB_PRIO0_EN
        if (adv && (win_s != '0)) begin
`else
        if (adv) begin
`endif
            last_d = win_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; resets to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined WIDTH x WIDTH multiplier among NREQ requesters.
//   clk, rst     - clock and synchronous active-high reset
//   en           - grant enable; in-flight operations complete regardless
//   bus          - mult_arbiter_if.slave: request handshake, operands, responses
//   mul_a, mul_b - operands to the multiplier (zero when nothing is accepted)
//   mul_lo/hi    - multiplier product, valid MUL_LAT cycles after the operands
//   busy         - any operation in flight
// Optional macro MULT_ARB_PRIO0_EN (see rr_arbiter): requester 0 strict priority.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int IDW     = idw_of(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    mult_arbiter_if.slave    bus,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic [WIDTH-1:0] mul_hi,
    output logic             busy
);

    logic [NREQ-1:0]  grant_s;
    logic [IDW-1:0]   gid_s;
    logic             accept_s;
    logic [WIDTH-1:0] mul_a_s;
    logic [WIDTH-1:0] mul_b_s;
    logic [NREQ-1:0]  rsp_valid_s;
    logic [IDW-1:0]   rsp_id_s;
    logic [WIDTH-1:0] rsp_lo_s;
    logic [WIDTH-1:0] rsp_hi_s;
    logic             busy_s;
    tag_t             tag_q [MUL_LAT];
    tag_t             tag_d [MUL_LAT];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (bus.req_valid),
        .adv      (accept_s),
        .grant    (grant_s),
        .grant_id (gid_s)
    );

    // A grant is only issued to a valid requester, so any grant is an accept.
    assign accept_s      = |(bus.req_valid & grant_s);
    assign bus.req_ready = grant_s;

    // Operand mux; idle cycles drive zero so the multiplier does not toggle.
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        if (accept_s) begin
            mul_a_s = bus.req_a[int'(gid_s)*WIDTH +: WIDTH];
            mul_b_s = bus.req_b[int'(gid_s)*WIDTH +: WIDTH];
        end else begin
            mul_a_s = '0;
            mul_b_s = '0;
        end
    end

    assign mul_a = mul_a_s;
    assign mul_b = mul_b_s;

    // Tag pipeline next state: owner of each operation travels with its product.
    always_comb begin
        tag_d[0] = '{vld: accept_s, id: gid_s};
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Tag pipeline registers; reset drops products still inside the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    // Response routing: the product is passed straight through to its owner.
    always_comb begin
        rsp_valid_s = '0;
        rsp_id_s    = '0;
        rsp_lo_s    = '0;
        rsp_hi_s    = '0;
        if (tag_q[MUL_LAT-1].vld) begin
            rsp_valid_s[tag_q[MUL_LAT-1].id] = 1'b1;
            rsp_id_s = tag_q[MUL_LAT-1].id;
            rsp_lo_s = mul_lo;
            rsp_hi_s = mul_hi;
        end else begin
            rsp_valid_s = '0;
        end
    end

    // Busy while any tag stage holds a live operation.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            busy_s = busy_s | tag_q[k].vld;
        end
    end

    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_id    = rsp_id_s;
    assign bus.rsp_lo    = rsp_lo_s;
    assign bus.rsp_hi    = rsp_hi_s;
    assign busy          = busy_s;

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipelined `multiplier` instance (WIDTH x WIDTH, 2-cycle latency) between NREQ requesters, e.g. modexp core, Montgomery reducer and key loader.
- Performs round-robin grant over valid/ready request channels and drives the multiplier operands.
- Tracks each in-flight operation's owner in a tag pipeline matched to the multiplier latency, and routes the lo/hi product back to the owner.

Parameters:
- WIDTH, 32, operand width; must match the multiplier.
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, multiplier latency in cycles, from operands driven to product valid.
- IDW, 2, requester id width; equals clog2(NREQ), or 1 when NREQ=2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  grant enable; when low, no new request is accepted.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_lo  in  WIDTH  multiplier out_l.
- mul_hi  in  WIDTH  multiplier out_h.
- rsp_valid  out  NREQ  one-hot result strobe, 1 cycle, no backpressure.
- rsp_id  out  IDW  owner of the current result.
- rsp_lo  out  WIDTH  low product word.
- rsp_hi  out  WIDTH  high product word.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset values:
  - rsp_valid=0, rsp_id=0, busy=0.
  - All tag-pipeline valid bits=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- Grant (combinational in the same cycle):
  - Search req_valid starting at index last+1 mod NREQ; the first set bit wins.
  - req_ready = onehot(winner) when en=1 and any req_valid is set; otherwise 0.
- Accept: req_valid[i] & req_ready[i].
  - On accept, mul_a/mul_b are driven from requester i's slices that cycle.
  - With no accept, mul_a/mul_b hold 0, which keeps the multiplier toggling low.
  - last <= i on accept only; last is unchanged in idle cycles.
- Throughput: one accept per cycle; no stall, since the multiplier is fully pipelined.
- Tag pipeline: MUL_LAT stages of {valid, id}.
  - Stage 0 loads {accept, i} every cycle; stage k loads stage k-1.
- Response: when stage MUL_LAT-1 is valid (accept in cycle T):
  - Result appears in cycle T+MUL_LAT as combinational pass-through.
  - rsp_valid = onehot(id), rsp_id = id, rsp_lo = mul_lo, rsp_hi = mul_hi.
  - When not valid: rsp_valid=0, rsp_lo/rsp_hi=0.
- busy = OR of all tag valid bits.
- en low:
  - req_ready=0 and the pointer is frozen.
  - In-flight operations still complete and respond.
- Reset mid-operation:
  - All tags are cleared, so products still emerging from the multiplier are discarded.
  - No rsp_valid in the 1..MUL_LAT cycles after reset.
- A requester deasserting req_valid before accept is legal; that is arbitration only, no request is lost.
- Same requester back-to-back: granted again only if no other requester is valid.
- Arithmetic: unsigned; full 2*WIDTH product split lo/hi with no truncation.
  - Example: 0xFFFFFFFF^2 gives hi=0xFFFFFFFE, lo=0x00000001.

Optional Feature:
- Macro MULT_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority: granted whenever req_valid[0]=1 and en=1.
  - The remaining requesters are round-robin among themselves.
  - The pointer updates only on non-zero grants.
- Undefined: all NREQ requesters are plain round-robin.

Decomposition:
- Package mult_arb_pkg holds:
  - the default WIDTH/NREQ/MUL_LAT constants;
  - an IDW function (clog2);
  - the tag struct typedef {logic vld; logic [IDW-1:0] id}.
- Sub-module rr_arbiter(NREQ): req vector, advance strobe and en in; one-hot grant out; owns the pointer register.
- mult_arbiter instantiates rr_arbiter, the operand mux, and the tag shift register.

Test Plan:
- Single request: rst; req_valid=0001, a=3, b=5 at T → req_ready=0001 at T; rsp_valid=0001, lo=15, hi=0 at T+2.
- Fairness: all four valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; the responses return in that order, each 2 cycles after its grant.
- Max operands: requester 2, a=b=0xFFFFFFFF → rsp_id=2, hi=0xFFFFFFFE, lo=0x00000001.
- en gating: en=0 with all valid for 3 cycles → req_ready=0 and busy falls to 0; en=1 → grant resumes at pointer+1.
- Reset mid-flight:
  - Accept at T, rst at T+1 → no rsp_valid at T+2 or T+3.
  - First post-reset grant goes to requester 0.
- With MULT_ARB_PRIO0_EN: req 0 and 1 valid continuously → req 0 is granted every cycle; drop req 0 → req 1 is granted next cycle.
